// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/branch sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned IMM_W = 4;
    localparam int unsigned OPC_W = 4;

    localparam logic [PC_W-1:0]  DEF_RESET_PC    = 16'h0000;
    localparam logic [OPC_W-1:0] DEF_HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Two's-complement widening of the short branch offset to PC width.
    function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC: PC + 1, plus the sign-extended offset when the branch is taken.
module branch_target_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0]  PC,
    input  logic [IMM_W-1:0] Branch_Imm,
    input  logic             Branch_Taken,
    output logic [PC_W-1:0]  Next_PC
);

    logic [PC_W-1:0] offset;

    // Wraps modulo 2^16 in both directions by construction.
    always_comb begin
        offset  = Branch_Taken ? sext_imm(Branch_Imm) : '0;
        Next_PC = PC + PC_W'(1) + offset;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/issue/execute sequencer owning the program counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0]  RESET_PC    = DEF_RESET_PC,
    parameter logic [OPC_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    output logic             Imem_Req,
    output logic [PC_W-1:0]  Imem_Addr,
    input  logic             Imem_Ack,
    input  logic [PC_W-1:0]  Imem_Data,
    output logic [PC_W-1:0]  Instr,
    output logic             Instr_Valid,
    input  logic             Exec_Done,
    input  logic             Branch_Taken,
    input  logic [IMM_W-1:0] Branch_Imm,
    output logic [PC_W-1:0]  PC,
    output logic             Halted
);

    state_t          state_q;
    state_t          state_d;
    logic            fetch_done;
    logic            exec_done;
    logic [PC_W-1:0] next_pc;

    branch_target_calc u_target (
        .PC           (PC),
        .Branch_Imm   (Branch_Imm),
        .Branch_Taken (Branch_Taken),
        .Next_PC      (next_pc)
    );

    // Next-state logic; handshake inputs only matter in their owning state.
    always_comb begin
        state_d    = state_q;
        fetch_done = 1'b0;
        exec_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (Imem_Ack) begin
                    fetch_done = 1'b1;
                    state_d    = (Imem_Data[PC_W-1 -: OPC_W] == HALT_OPCODE) ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (Exec_Done) begin
                    exec_done = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs registered from the next state so they align with the state they describe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Imem_Req    <= 1'b0;
            Instr_Valid <= 1'b0;
            Halted      <= 1'b0;
            Instr       <= '0;
            PC          <= RESET_PC;
        end else begin
            Imem_Req    <= (state_d == ST_FETCH);
            Instr_Valid <= (state_d == ST_ISSUE);
            Halted      <= (state_d == ST_HALT);
            if (fetch_done) Instr <= Imem_Data;
            if (exec_done)  PC    <= next_pc;
        end
    end

    assign Imem_Addr = PC;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a PC-arithmetic reference model.
module tb_pc_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic        Imem_Req;
    logic [15:0] Imem_Addr;
    logic        Imem_Ack;
    logic [15:0] Imem_Data;
    logic [15:0] Instr;
    logic        Instr_Valid;
    logic        Exec_Done;
    logic        Branch_Taken;
    logic [3:0]  Branch_Imm;
    logic [15:0] PC;
    logic        Halted;

    // Second instance exercising a non-default reset PC.
    logic        w_start, w_req, w_ack, w_valid, w_done, w_taken, w_halted;
    logic [15:0] w_addr, w_data, w_instr, w_pc;
    logic [3:0]  w_imm;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_pc;

    pc_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
        .Instr(Instr), .Instr_Valid(Instr_Valid),
        .Exec_Done(Exec_Done), .Branch_Taken(Branch_Taken), .Branch_Imm(Branch_Imm),
        .PC(PC), .Halted(Halted)
    );

    pc_sequencer #(.RESET_PC(16'hFFFF)) dut_w (
        .Clk(Clk), .Rst_n(Rst_n), .Start(w_start),
        .Imem_Req(w_req), .Imem_Addr(w_addr), .Imem_Ack(w_ack), .Imem_Data(w_data),
        .Instr(w_instr), .Instr_Valid(w_valid),
        .Exec_Done(w_done), .Branch_Taken(w_taken), .Branch_Imm(w_imm),
        .PC(w_pc), .Halted(w_halted)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        return {4'($urandom_range(0, 14)), 12'($urandom)};
    endfunction

    // Reference next PC: PC + 1 + signed offset when taken, modulo 2^16.
    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic taken, input logic [3:0] imm);
        int off;
        off = 0;
        if (taken) off = (int'(imm) > 7) ? int'(imm) - 16 : int'(imm);
        return 16'((int'(pc) + 1 + off) % 65536 + 65536);
    endfunction

    task automatic do_reset();
        Start = 0; Imem_Ack = 0; Imem_Data = 0; Exec_Done = 0; Branch_Taken = 0; Branch_Imm = 0;
        w_start = 0; w_ack = 0; w_data = 0; w_done = 0; w_taken = 0; w_imm = 0;
        Rst_n = 0;
        #3;
        Rst_n = 1;
        tick();
        model_pc = 16'h0000;
    endtask

    task automatic do_start();
        Start = 1;
        tick();
        Start = 0;
    endtask

    // One instruction: fetch with ack delay, issue, execute with done delay; checks along the way.
    task automatic step(input logic taken, input logic [3:0] imm, input int ack_dly,
                        input int done_dly, input logic [15:0] word);
        total++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== model_pc)
            begin bad++; $display("FAIL fetch_entry req=%b addr=%h expected req=1 addr=%h", Imem_Req, Imem_Addr, model_pc); end
        for (int k = 0; k < ack_dly; k++) begin
            Imem_Ack = 0; Start = 1'($urandom);
            Exec_Done = 1'($urandom); Branch_Taken = 1'($urandom); Branch_Imm = 4'($urandom);
            tick();
            total++;
            if (Imem_Req !== 1'b1 || Imem_Addr !== model_pc || Instr_Valid !== 1'b0 || PC !== model_pc)
                begin bad++; $display("FAIL fetch_hold req=%b addr=%h valid=%b pc=%h expected 1/%h/0/%h",
                                      Imem_Req, Imem_Addr, Instr_Valid, PC, model_pc, model_pc); end
        end
        Start = 0; Exec_Done = 0; Branch_Taken = 0;
        Imem_Ack = 1; Imem_Data = word;
        tick();
        Imem_Ack = 0; Imem_Data = 16'($urandom);
        if (word[15:12] == 4'hF) begin
            total++;
            if (Halted !== 1'b1 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || PC !== model_pc)
                begin bad++; $display("FAIL halt_entry halted=%b req=%b valid=%b pc=%h expected 1/0/0/%h",
                                      Halted, Imem_Req, Instr_Valid, PC, model_pc); end
            return;
        end
        total++;
        if (Instr_Valid !== 1'b1 || Instr !== word || Imem_Req !== 1'b0 || Halted !== 1'b0)
            begin bad++; $display("FAIL issue valid=%b instr=%h req=%b halted=%b expected 1/%h/0/0",
                                  Instr_Valid, Instr, Imem_Req, Halted, word); end
        Imem_Ack = 1'($urandom);
        tick();
        total++;
        if (Instr_Valid !== 1'b0)
            begin bad++; $display("FAIL valid_width valid=%b expected 0", Instr_Valid); end
        for (int k = 0; k < done_dly; k++) begin
            Start = 1'($urandom);
            tick();
            total++;
            if (PC !== model_pc || Instr_Valid !== 1'b0 || Imem_Req !== 1'b0)
                begin bad++; $display("FAIL exec_wait pc=%h valid=%b req=%b expected %h/0/0",
                                      PC, Instr_Valid, Imem_Req, model_pc); end
        end
        Start = 0; Imem_Ack = 0;
        Exec_Done = 1; Branch_Taken = taken; Branch_Imm = imm;
        tick();
        Exec_Done = 0; Branch_Taken = 0; Branch_Imm = 4'($urandom);
        model_pc = ref_next(model_pc, taken, imm);
        total++;
        if (PC !== model_pc || Imem_Req !== 1'b1 || Imem_Addr !== model_pc)
            begin bad++; $display("FAIL next_pc pc=%h req=%b addr=%h expected pc=%h req=1", PC, Imem_Req, Imem_Addr, model_pc); end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (PC !== 16'h0000 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || Halted !== 1'b0 || Instr !== 16'h0000)
            begin bad++; $display("FAIL reset_state pc=%h req=%b valid=%b halted=%b instr=%h expected 0000/0/0/0/0000",
                                  PC, Imem_Req, Instr_Valid, Halted, Instr); end
        Imem_Ack = 1; Exec_Done = 1; Branch_Taken = 1; Branch_Imm = 4'h7;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (PC !== 16'h0000 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b0)
                begin bad++; $display("FAIL idle_ignore pc=%h req=%b valid=%b expected 0000/0/0", PC, Imem_Req, Instr_Valid); end
        end
        Imem_Ack = 0; Exec_Done = 0; Branch_Taken = 0;
    endtask

    task automatic test_sequential();
        do_reset();
        do_start();
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 0, 0, rand_word());
        total++;
        if (Halted !== 1'b0)
            begin bad++; $display("FAIL seq_halted halted=%b expected 0", Halted); end
    endtask

    task automatic test_branch();
        do_reset();
        do_start();
        step(1'b1, 4'b0111, 0, 0, rand_word());   // 0x0008
        step(1'b1, 4'b0111, 1, 0, rand_word());   // 0x0010
        step(1'b1, 4'b1100, 0, 1, rand_word());   // 0x000D
        step(1'b1, 4'b1000, 0, 0, rand_word());   // 0x0006
        step(1'b1, 4'b1110, 0, 0, rand_word());   // 0x0005
        step(1'b1, 4'b0011, 0, 0, rand_word());   // 0x0009
        step(1'b1, 4'b0111, 0, 0, rand_word());   // 0x0011
        step(1'b1, 4'b0111, 0, 0, rand_word());   // 0x0019
        step(1'b1, 4'b0110, 0, 0, rand_word());   // 0x0020
        step(1'b0, 4'b1000, 2, 2, rand_word());   // 0x0021
        total++;
        if (PC !== 16'h0021)
            begin bad++; $display("FAIL branch_path pc=%h expected 0021", PC); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_start();
        step(1'b1, 4'b0001, 0, 0, rand_word());   // 0x0002
        step(1'b1, 4'b1000, 0, 0, rand_word());   // 0xFFFB
        total++;
        if (PC !== 16'hFFFB)
            begin bad++; $display("FAIL wrap_down pc=%h expected fffb", PC); end
        step(1'b1, 4'b0010, 0, 0, rand_word());   // 0xFFFE
        step(1'b1, 4'b0111, 0, 0, rand_word());   // 0x0006
        total++;
        if (PC !== 16'h0006)
            begin bad++; $display("FAIL wrap_up pc=%h expected 0006", PC); end
    endtask

    task automatic test_reset_pc_ffff();
        do_reset();
        total++;
        if (w_pc !== 16'hFFFF || w_req !== 1'b0)
            begin bad++; $display("FAIL rstpc_reset pc=%h req=%b expected ffff/0", w_pc, w_req); end
        w_start = 1; tick(); w_start = 0;
        total++;
        if (w_req !== 1'b1 || w_addr !== 16'hFFFF)
            begin bad++; $display("FAIL rstpc_fetch req=%b addr=%h expected 1/ffff", w_req, w_addr); end
        w_ack = 1; w_data = 16'h1234; tick(); w_ack = 0;
        total++;
        if (w_valid !== 1'b1 || w_instr !== 16'h1234)
            begin bad++; $display("FAIL rstpc_issue valid=%b instr=%h expected 1/1234", w_valid, w_instr); end
        tick();
        w_done = 1; w_taken = 0; w_imm = 4'b0111; tick(); w_done = 0;
        total++;
        if (w_pc !== 16'h0000 || w_req !== 1'b1 || w_addr !== 16'h0000)
            begin bad++; $display("FAIL rstpc_wrap pc=%h req=%b addr=%h expected 0000/1/0000", w_pc, w_req, w_addr); end
    endtask

    task automatic test_ack_delay();
        do_reset();
        do_start();
        step(1'b0, 4'h0, 4, 2, rand_word());
        step(1'b1, 4'b0101, 4, 3, rand_word());
        step(1'b1, 4'b1011, 4, 0, rand_word());
    endtask

    task automatic test_halt();
        do_reset();
        do_start();
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 0, 0, rand_word());
        step(1'b0, 4'h0, 1, 0, 16'hF123);
        for (int k = 0; k < 5; k++) begin
            Start = 1; Imem_Ack = 1; Exec_Done = 1; Branch_Taken = 1; Branch_Imm = 4'h7;
            tick();
            total++;
            if (Halted !== 1'b1 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || PC !== 16'h0003)
                begin bad++; $display("FAIL halt_hold halted=%b req=%b valid=%b pc=%h expected 1/0/0/0003",
                                      Halted, Imem_Req, Instr_Valid, PC); end
        end
        Start = 0; Imem_Ack = 0; Exec_Done = 0; Branch_Taken = 0;
    endtask

    task automatic test_reset_mid();
        // Mid-FETCH
        do_reset();
        do_start();
        step(1'b1, 4'b0011, 0, 0, rand_word());   // 0x0004, now fetching
        #2 Rst_n = 0;
        #1;
        total++;
        if (Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || Halted !== 1'b0 || PC !== 16'h0000)
            begin bad++; $display("FAIL rst_fetch req=%b valid=%b halted=%b pc=%h expected 0/0/0/0000",
                                  Imem_Req, Instr_Valid, Halted, PC); end
        Rst_n = 1;
        Imem_Ack = 1;
        tick(); tick();
        total++;
        if (Imem_Req !== 1'b0 || PC !== 16'h0000 || Instr_Valid !== 1'b0)
            begin bad++; $display("FAIL rst_idle req=%b pc=%h valid=%b expected 0/0000/0", Imem_Req, PC, Instr_Valid); end
        Imem_Ack = 0;
        // Mid-ISSUE
        do_start();
        model_pc = 16'h0000;
        step(1'b1, 4'b0011, 0, 0, rand_word());
        Imem_Ack = 1; Imem_Data = rand_word(); tick(); Imem_Ack = 0;
        #2 Rst_n = 0;
        #1;
        total++;
        if (Instr_Valid !== 1'b0 || PC !== 16'h0000 || Instr !== 16'h0000)
            begin bad++; $display("FAIL rst_issue valid=%b pc=%h instr=%h expected 0/0000/0000", Instr_Valid, PC, Instr); end
        Rst_n = 1;
        tick();
        // Mid-EXEC, with Exec_Done pending
        do_start();
        model_pc = 16'h0000;
        step(1'b1, 4'b0101, 0, 0, rand_word());   // 0x0006
        Imem_Ack = 1; Imem_Data = rand_word(); tick(); Imem_Ack = 0;
        tick();
        Exec_Done = 1; Branch_Taken = 1; Branch_Imm = 4'b0111;
        #2 Rst_n = 0;
        #1;
        total++;
        if (Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || Halted !== 1'b0 || PC !== 16'h0000)
            begin bad++; $display("FAIL rst_exec req=%b valid=%b halted=%b pc=%h expected 0/0/0/0000",
                                  Imem_Req, Instr_Valid, Halted, PC); end
        Rst_n = 1;
        tick();
        total++;
        if (PC !== 16'h0000 || Imem_Req !== 1'b0)
            begin bad++; $display("FAIL rst_exec_idle pc=%h req=%b expected 0000/0", PC, Imem_Req); end
        Exec_Done = 0; Branch_Taken = 0;
        do_start();
        model_pc = 16'h0000;
        step(1'b0, 4'h0, 0, 0, rand_word());
    endtask

    task automatic test_random();
        do_reset();
        do_start();
        for (int n = 0; n < 40; n++)
            step(1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rand_word());
    endtask

    initial begin
        Rst_n = 1'b1;
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_reset_pc_ffff();
        test_ack_delay();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
